// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide asynchronous-read RAM between the fetch (IF) and
// memory (MEM) pipeline stages. Each access is split into 1 (byte) or 4 (word) byte beats,
// words assembled big-endian. Optional macro ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; without it MEM always wins over IF.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_mem_q;
    logic              word_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        beat_q;
    logic [31:0]       wdata_q;
    logic [23:0]       shift_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;

    logic              grant_mem;
    logic              grant_if;
    logic              prefer_mem;
    logic              last_beat;
    logic [31:0]       rd_word;

    // Address bits outside the RAM and the fetch byte offset carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{if_addr[31:ADDR_W], if_addr[1:0], mem_addr[31:ADDR_W]};

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_mem_q;

    // Round-robin pointer: after each grant the other port is preferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_mem_q <= 1'b1;
        end else if (grant_mem) begin
            rr_mem_q <= 1'b0;
        end else if (grant_if) begin
            rr_mem_q <= 1'b1;
        end
    end

    assign prefer_mem = rr_mem_q;
`else
    assign prefer_mem = 1'b1;
`endif

    assign grant_mem = (state_q == StIdle) && mem_req && (!if_req || prefer_mem);
    assign grant_if  = (state_q == StIdle) && if_req && !grant_mem;

    assign last_beat = !word_q || (beat_q == 2'd3);
    // Earlier beats sit in shift_q, the current beat comes straight from the RAM.
    assign rd_word   = word_q ? {shift_q, ram_rdata} : {24'h0, ram_rdata};

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_mem || grant_if) state_d = StXfer;
            StXfer:  if (last_beat) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request latching, beat sequencing and read-data assembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_mem_q <= 1'b0;
            word_q      <= 1'b0;
            we_q        <= 1'b0;
            base_q      <= '0;
            beat_q      <= 2'd0;
            wdata_q     <= 32'h0;
            shift_q     <= 24'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    beat_q <= 2'd0;
                    if (grant_mem) begin
                        owner_mem_q <= 1'b1;
                        word_q      <= !mem_size;
                        we_q        <= mem_we;
                        wdata_q     <= mem_wdata;
                        base_q      <= mem_size ? mem_addr[ADDR_W-1:0]
                                                : {mem_addr[ADDR_W-1:2], 2'b00};
                    end else if (grant_if) begin
                        owner_mem_q <= 1'b0;
                        word_q      <= 1'b1;
                        we_q        <= 1'b0;
                        wdata_q     <= 32'h0;
                        base_q      <= {if_addr[ADDR_W-1:2], 2'b00};
                    end
                end
                StXfer: begin
                    beat_q  <= beat_q + 2'd1;
                    shift_q <= {shift_q[15:0], ram_rdata};
                    if (last_beat && !we_q) begin
                        if (owner_mem_q) begin
                            mem_rdata_q <= rd_word;
                        end else begin
                            if_rdata_q <= rd_word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM drive during beats and completion pulse in the response cycle.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = 8'h0;
        ram_we    = 1'b0;
        if_done   = 1'b0;
        mem_done  = 1'b0;
        unique case (state_q)
            StXfer: begin
                ram_addr = base_q + ADDR_W'(beat_q);
                // A reset arriving mid-access suppresses the beat it lands on.
                ram_we   = we_q & ~reset;
                if (word_q) begin
                    unique case (beat_q)
                        2'd0:    ram_wdata = wdata_q[31:24];
                        2'd1:    ram_wdata = wdata_q[23:16];
                        2'd2:    ram_wdata = wdata_q[15:8];
                        default: ram_wdata = wdata_q[7:0];
                    endcase
                end else begin
                    ram_wdata = wdata_q[7:0];
                end
            end
            StResp: begin
                if_done  = !owner_mem_q;
                mem_done = owner_mem_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized batches, checked by a
// scoreboard fed from a transaction-level memory model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          if_done;
    logic          mem_req;
    logic          mem_we;
    logic          mem_size;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic          stall_if;
    logic          stall_mem;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata;

    mem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT.
    logic [7:0] ram [256];
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic        size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } op_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic [7:0]  mm [256];
    exp_t        q_if[$];
    exp_t        q_mem[$];
    op_t         if_ops[$];
    op_t         mem_ops[$];
    logic [31:0] last_if;
    logic [31:0] last_mem;
    bit          pref_mem;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    function automatic op_t mk(input logic we, input logic size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        op_t o;
        o.we = we; o.size = size; o.addr = addr; o.wdata = wdata;
        return o;
    endfunction

    function automatic op_t rand_op(input bit is_mem);
        op_t o;
        o.addr  = $urandom;
        o.wdata = $urandom;
        o.we    = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
        o.size  = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
        return o;
    endfunction

    // Memory model: applies one access to the shadow image, returns read data.
    function automatic logic [31:0] model_access(input op_t op);
        int          a;
        logic [31:0] r;
        a = int'(op.addr[7:0]);
        r = 32'h0;
        if (op.size) begin
            if (op.we) mm[a] = op.wdata[7:0];
            else r = {24'h0, mm[a]};
        end else begin
            a = a & 'hFC;
            for (int i = 0; i < 4; i++) begin
                if (op.we) mm[a + i] = 8'(op.wdata >> (24 - 8 * i));
                else r = (r << 8) | 32'(mm[a + i]);
            end
        end
        return r;
    endfunction

    function automatic void model_reset();
        pref_mem = 1'b1;
        last_if  = 32'h0;
        last_mem = 32'h0;
    endfunction

    task automatic wait_done(input bit is_mem, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = is_mem ? mem_done : if_done;
        end
    endtask

    task automatic drive_if();
        bit ok = 1'b1;
        for (int k = 0; k < if_ops.size() && ok; k++) begin
            if_addr = if_ops[k].addr;
            if_req  = 1'b1;
            wait_done(1'b0, ok);
            if (!ok) begin
                compared++; mismatched++;
                $display("FAIL if_done_timeout @cyc %0d: got no done, expected done", cyc);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if_req = 1'b0;
    endtask

    task automatic drive_mem();
        bit ok = 1'b1;
        for (int k = 0; k < mem_ops.size() && ok; k++) begin
            mem_we    = mem_ops[k].we;
            mem_size  = mem_ops[k].size;
            mem_addr  = mem_ops[k].addr;
            mem_wdata = mem_ops[k].wdata;
            mem_req   = 1'b1;
            wait_done(1'b1, ok);
            if (!ok) begin
                compared++; mismatched++;
                $display("FAIL mem_done_timeout @cyc %0d: got no done, expected done", cyc);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        mem_req = 1'b0;
    endtask

    // Both ports raise their first request now and re-request back-to-back until their
    // lists run out. Grant order follows the arbitration rule; each slot costs 6 or 3 cycles.
    task automatic run_batch();
        int          t  = cyc;
        int          ni = 0;
        int          nm = 0;
        bit          take_mem;
        op_t         op;
        exp_t        e;
        logic [31:0] r;
        while (ni < if_ops.size() || nm < mem_ops.size()) begin
            take_mem = (nm < mem_ops.size()) && (ni >= if_ops.size() || pref_mem);
            if (take_mem) op = mem_ops[nm];
            else op = if_ops[ni];
            e.cyc = t + (op.size ? 2 : 5);
            r = model_access(op);
            if (take_mem) begin
                if (!op.we) last_mem = r;
                e.data = last_mem;
                q_mem.push_back(e);
                nm++;
            end else begin
                last_if = r;
                e.data  = last_if;
                q_if.push_back(e);
                ni++;
            end
`ifdef ARB_ROUND_ROBIN_EN
            pref_mem = !take_mem;
`endif
            t = e.cyc + 1;
        end
        fork
            drive_if();
            drive_mem();
        join
    endtask

    task automatic probe_fetch();
        @(negedge clk);
        chk("fetch_stall_req_cycle", 32'(stall_if), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fetch_ram_addr", 32'(ram_addr), 32'h10 + 32'(i));
            chk("fetch_ram_we", 32'(ram_we), 32'd0);
            chk("fetch_stall", 32'(stall_if), 32'd1);
        end
    endtask

    task automatic probe_bytewr();
        @(negedge clk);
        @(negedge clk);
        chk("bytewr_ram_we", 32'(ram_we), 32'd1);
        chk("bytewr_ram_addr", 32'(ram_addr), 32'h21);
        chk("bytewr_ram_wdata", 32'(ram_wdata), 32'hAB);
        @(negedge clk);
        chk("bytewr_resp_we", 32'(ram_we), 32'd0);
    endtask

    task automatic probe_stable(input logic [31:0] prev);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("if_rdata_stable", if_rdata, prev);
        end
    endtask

    // Monitor: every done pulse consumes one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (if_done) begin
                if (q_if.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL if_done_unexpected @cyc %0d: got done, expected none", cyc);
                end else begin
                    e = q_if.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (mem_done) begin
                if (q_mem.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL mem_done_unexpected @cyc %0d: got done, expected none", cyc);
                end else begin
                    e = q_mem.pop_front();
                    chk("mem_rdata", mem_rdata, e.data);
                    chk("mem_done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog @cyc %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] prev;
        int          diffs;
        int          kind;

        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            case (i)
                'h10: b = 8'hE3;
                'h11: b = 8'hA0;
                'h12: b = 8'h00;
                'h13: b = 8'h01;
                'h30: b = 8'h55;
                'h31: b = 8'h66;
                'h32: b = 8'h77;
                'h33: b = 8'h88;
                default: ;
            endcase
            ram[i] <= b;
            mm[i] = b;
        end
        model_reset();

        // Reset held two cycles with both requests up.
        reset     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h40;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_size  = 1'b0;
        mem_addr  = 32'h44;
        mem_wdata = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        chk("rst_stall_if", 32'(stall_if), 32'd1);
        chk("rst_stall_mem", 32'(stall_mem), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        if_ops.delete(); mem_ops.delete();
        if_ops.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0));
        mem_ops.push_back(mk(1'b0, 1'b0, 32'h44, 32'h0));
        run_batch();

        // Fetch of the word at 0x10 through an unaligned address.
        if_ops.delete(); mem_ops.delete();
        if_ops.push_back(mk(1'b0, 1'b0, 32'h12, 32'h0));
        fork
            run_batch();
            probe_fetch();
        join

        // Byte write then byte read-back.
        if_ops.delete(); mem_ops.delete();
        mem_ops.push_back(mk(1'b1, 1'b1, 32'h21, 32'h123456AB));
        fork
            run_batch();
            probe_bytewr();
        join
        mem_ops.delete();
        mem_ops.push_back(mk(1'b0, 1'b1, 32'h21, 32'h0));
        run_batch();

        // Simultaneous word reads: IF output must hold while MEM is served.
        if_ops.delete(); mem_ops.delete();
        if_ops.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0));
        mem_ops.push_back(mk(1'b0, 1'b0, 32'h50, 32'h0));
        prev = last_if;
        fork
            run_batch();
            probe_stable(prev);
        join

        // Word write to 0x30 cut short by reset during beat 2.
        mem_we    = 1'b1;
        mem_size  = 1'b0;
        mem_addr  = 32'h30;
        mem_wdata = 32'h11223344;
        mem_req   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset   = 1'b1;
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mm['h30] = 8'h11;
        mm['h31] = 8'h22;
        model_reset();
        @(negedge clk);
        chk("abort_mem_rdata", mem_rdata, 32'h0);
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        if_ops.delete(); mem_ops.delete();
        mem_ops.push_back(mk(1'b0, 1'b0, 32'h30, 32'h0));
        run_batch();

        // Both ports requesting continuously.
        if_ops.delete(); mem_ops.delete();
        for (int i = 0; i < 2; i++) begin
            if_ops.push_back(rand_op(1'b0));
            mem_ops.push_back(rand_op(1'b1));
        end
        run_batch();

        // Randomized batches.
        for (int n = 0; n < 40; n++) begin
            if_ops.delete(); mem_ops.delete();
            kind = $urandom_range(0, 2);
            if (kind != 1) repeat ($urandom_range(1, 2)) if_ops.push_back(rand_op(1'b0));
            if (kind != 0) repeat ($urandom_range(1, 2)) mem_ops.push_back(rand_op(1'b1));
            run_batch();
        end

        repeat (10) @(negedge clk);
        chk("if_queue_left", 32'(q_if.size()), 32'd0);
        chk("mem_queue_left", 32'(q_mem.size()), 32'd0);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== mm[i]) diffs++;
        chk("ram_image_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single byte-wide instruction/data RAM (256x8, asynchronous read) between the pipeline's fetch stage (IF) and memory stage (MEM). Each request is sequenced into 1 or 4 byte beats. 32-bit words are assembled big-endian. Stall outputs hold the requesting stage until its access completes. Sits between the pipeline stages and the RAM inside the top-level `main`.

## Interface

Parameters:
- `ADDR_W`, default 8: RAM address width; depth is 2^ADDR_W bytes.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `if_req`, in, 1: fetch request; held until `if_done`.
- `if_addr`, in, 32: fetch byte address; bits [1:0] ignored.
- `if_rdata`, out, 32: fetched word.
- `if_done`, out, 1: one-cycle completion pulse.
- `mem_req`, in, 1: data request; held until `mem_done`.
- `mem_we`, in, 1: 1 = write, 0 = read.
- `mem_size`, in, 1: 0 = word, 1 = byte.
- `mem_addr`, in, 32: data byte address.
- `mem_wdata`, in, 32: write data.
- `mem_rdata`, out, 32: read data.
- `mem_done`, out, 1: one-cycle completion pulse.
- `stall_if`, out, 1: `if_req & ~if_done`, combinational.
- `stall_mem`, out, 1: `mem_req & ~mem_done`, combinational.
- `ram_addr`, out, ADDR_W: RAM byte address.
- `ram_wdata`, out, 8: RAM write byte.
- `ram_we`, out, 1: RAM write enable.
- `ram_rdata`, in, 8: RAM read byte, combinational from `ram_addr`.

## Operation

- FSM states: IDLE, XFER, RESP.
- **IDLE**
  - Sample `if_req` and `mem_req`.
  - On a grant, latch the following and go to XFER:
    - owner;
    - base address;
    - beat count (4 for word, 1 for byte);
    - `we`;
    - `wdata`.
  - Word base is addr[ADDR_W-1:2],2'b00. Byte base is addr[ADDR_W-1:0]. Bits above ADDR_W are ignored.
  - IF requests are always word reads.
- **XFER**
  - Beat counter b runs 0..count-1.
  - `ram_addr` = base + b, wrapping modulo 2^ADDR_W.
  - `ram_we` = latched `we`.
  - Word beat b carries byte lane [31-8b -: 8]: write byte or captured read byte. Big-endian, so b=0 is bits 31:24.
  - Byte read captures into [7:0] with [31:8] zero. Byte write drives `wdata[7:0]`.
  - After the last beat, go to RESP.
- **RESP**
  - Assert the owner's `*_done` for exactly one cycle.
  - Owner's `*_rdata` updates this cycle; on writes it is unchanged.
  - Return to IDLE.
- Arbitration when both request in IDLE: MEM wins (older instruction), unless changed by Configuration.
- Requester handshake:
  - Requesters deassert `req` at the edge where `done` is sampled high.
  - A `req` still high in the following IDLE cycle is a new request.
  - Request inputs are ignored outside IDLE; the latched copies are used.
- Outside XFER: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.

## Timing

- Request seen in IDLE at cycle T:
  - word access: XFER T+1..T+4, `done` at T+5;
  - byte access: XFER T+1, `done` at T+2.
- Back-to-back requests: next grant no earlier than T+6 for a word, T+3 for a byte.
- The losing requester waits for the full winner transaction plus one IDLE cycle.
- Reset values:
  - state IDLE;
  - `if_rdata`=0, `mem_rdata`=0;
  - `if_done`=0, `mem_done`=0;
  - `ram_addr`=0, `ram_wdata`=0, `ram_we`=0;
  - round-robin pointer = MEM-preferred.
  - `stall_*` follow `req` directly.
- Reset mid-XFER/RESP:
  - abort next cycle to IDLE;
  - no `done` issued;
  - bytes already written stay in RAM;
  - a requester still holding `req` is re-arbitrated from scratch.
- Address wrap: a word at base 0xFC on ADDR_W=8 touches 0xFC..0xFF only; a word access never crosses its aligned word.

## Configuration

- `ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, the port not granted most recently wins.
  - The pointer updates on every grant, and on reset to MEM-preferred.
- Undefined: fixed priority, MEM over IF always. IF can starve while MEM re-requests continuously.

## Test plan

- Reset held 2 cycles with both `req` high -> all registered outputs 0, state IDLE, no `ram_we`; first grant in the cycle after reset drops, MEM first.
- RAM[0x10..0x13]=E3,A0,00,01; `if_req`, `if_addr`=0x12 -> `ram_addr` 0x10..0x13 over 4 cycles, `if_rdata`=0xE3A00001, `if_done` at T+5, `stall_if` high T..T+4.
- `mem_req` byte write, `mem_addr`=0x21, `mem_wdata`=0x123456AB -> single beat `ram_we`=1, `ram_addr`=0x21, `ram_wdata`=0xAB; `mem_done` at T+2; byte read-back gives 0x000000AB.
- IF and MEM word reads raised on the same cycle -> MEM completes at T+5, IF granted T+6, `if_done` T+11; `if_rdata` stable throughout the MEM access.
- Word write at 0x30 aborted by `reset` during beat 2 -> RAM 0x30..0x31 updated, 0x32..0x33 unchanged, no `mem_done`.
- With `ARB_ROUND_ROBIN_EN`: both ports requesting continuously -> grants alternate MEM, IF, MEM, IF. Without it -> MEM granted every time.
